// File: rtl/datamover_rep_sched.sv
// datamover_rep_sched
// -----------------------------------------------------------------------------
// Job scheduler for the datamover HWPE. On a start pulse it launches every
// enabled channel, waits until all of them have drained, and repeats the whole
// copy n_rep times. Between repetitions every channel address advances by the
// per-repetition stride, wrapping modulo 2^AW. A per-repetition cycle timeout
// aborts a hung job.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous clear, same effect as reset
//   start_i                one-cycle start pulse (ignored unless idle)
//   ch_mask_i, n_rep_i     channel enables / repetition count, sampled at start
//   src_base_i, dst_base_i per-channel base addresses, sampled in LOAD
//   src/dst_rep_stride_i   address increment per repetition
//   timeout_i              max WORKING cycles per repetition (0 = disabled)
//   sink_done_i            per-channel sink done (pulse or level)
//   fifo_empty_i           per-channel TCDM FIFO empty
//   src/dst_valid_o        per-channel start strobes
//   src/dst_addr_o         current per-channel base addresses
//   busy_o                 high whenever not idle
//   done_o, timeout_o      completion pulse; timeout_o marks an abort
//   rep_cnt_o              repetitions completed in the current job
//
// Handshake: src_valid_o/dst_valid_o are single-cycle launch strobes with no
// ready; a channel is considered finished once sink_done_i and fifo_empty_i
// are both high in the same WORKING cycle. Every output is decoded from
// registers only, so there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module datamover_rep_sched #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TO_W  = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [N_CH-1:0]           ch_mask_i,
  input  logic [CNT_W-1:0]          n_rep_i,
  input  logic [N_CH-1:0][AW-1:0]   src_base_i,
  input  logic [N_CH-1:0][AW-1:0]   dst_base_i,
  input  logic [AW-1:0]             src_rep_stride_i,
  input  logic [AW-1:0]             dst_rep_stride_i,
  input  logic [TO_W-1:0]           timeout_i,
  input  logic [N_CH-1:0]           sink_done_i,
  input  logic [N_CH-1:0]           fifo_empty_i,
  output logic [N_CH-1:0]           src_valid_o,
  output logic [N_CH-1:0]           dst_valid_o,
  output logic [N_CH-1:0][AW-1:0]   src_addr_o,
  output logic [N_CH-1:0][AW-1:0]   dst_addr_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      timeout_o,
  output logic [CNT_W-1:0]          rep_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD, STARTING, WORKING, NEXT, FINISHED, ABORT
  } state_e;

  state_e                   state_q,    state_d;
  logic [N_CH-1:0]          mask_q,     mask_d;
  logic [N_CH-1:0]          done_q,     done_d;
  logic [CNT_W-1:0]         rep_left_q, rep_left_d;
  logic [CNT_W-1:0]         rep_cnt_q,  rep_cnt_d;
  logic [TO_W-1:0]          to_cnt_q,   to_cnt_d;
  logic [N_CH-1:0][AW-1:0]  src_addr_q, src_addr_d;
  logic [N_CH-1:0][AW-1:0]  dst_addr_q, dst_addr_d;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    done_d     = done_q;
    rep_left_d = rep_left_q;
    rep_cnt_d  = rep_cnt_q;
    to_cnt_d   = to_cnt_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mask_d     = ch_mask_i;
          rep_left_d = (n_rep_i == '0) ? CNT_W'(1) : n_rep_i;
          // An empty mask has nothing to launch: report completion at once.
          state_d    = (ch_mask_i == '0) ? FINISHED : LOAD;
        end
      end
      LOAD: begin
        src_addr_d = src_base_i;
        dst_addr_d = dst_base_i;
        rep_cnt_d  = '0;
        state_d    = STARTING;
      end
      STARTING: begin
        done_d   = '0;
        to_cnt_d = '0;
        state_d  = WORKING;
      end
      WORKING: begin
        // Folding this cycle's completions in lets a channel finishing now
        // end the repetition without an extra cycle.
        done_d   = done_q | (sink_done_i & fifo_empty_i & mask_q);
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (&(done_d | ~mask_q)) begin
          rep_cnt_d = rep_cnt_q + CNT_W'(1);
          state_d   = (rep_left_q == CNT_W'(1)) ? FINISHED : NEXT;
        end else if ((timeout_i != '0) && (to_cnt_d >= timeout_i)) begin
          state_d = ABORT;
        end
      end
      NEXT: begin
        for (int i = 0; i < int'(N_CH); i++) begin
          src_addr_d[i] = src_addr_q[i] + src_rep_stride_i;
          dst_addr_d[i] = dst_addr_q[i] + dst_rep_stride_i;
        end
        rep_left_d = rep_left_q - CNT_W'(1);
        state_d    = STARTING;
      end
      FINISHED: state_d = IDLE;
      ABORT:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      done_q     <= '0;
      rep_left_q <= '0;
      rep_cnt_q  <= '0;
      to_cnt_q   <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      done_q     <= '0;
      rep_left_q <= '0;
      rep_cnt_q  <= '0;
      to_cnt_q   <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      done_q     <= done_d;
      rep_left_q <= rep_left_d;
      rep_cnt_q  <= rep_cnt_d;
      to_cnt_q   <= to_cnt_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
    end
  end

  assign src_valid_o = (state_q == STARTING) ? mask_q : '0;
  assign dst_valid_o = (state_q == STARTING) ? mask_q : '0;
  assign src_addr_o  = src_addr_q;
  assign dst_addr_o  = dst_addr_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == FINISHED) || (state_q == ABORT);
  assign timeout_o   = (state_q == ABORT);
  assign rep_cnt_o   = rep_cnt_q;

endmodule

// File: tb/tb_datamover_rep_sched.sv
// Bench for datamover_rep_sched. A job is described by its configuration and,
// per repetition and channel, the WORKING-cycle offsets at which sink_done and
// fifo_empty go high (held as levels). A timeline model derives from that the
// cycle of every launch, completion and abort, and each scenario compares the
// DUT outputs cycle by cycle against it.
module tb_datamover_rep_sched;
  localparam int N_CH    = 2;
  localparam int AW      = 32;
  localparam int CNT_W   = 16;
  localparam int TO_W    = 20;
  localparam int MAX_REP = 6;
  localparam int NEVER   = 100000;

  typedef logic [N_CH-1:0][AW-1:0] addr_vec_t;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                 clear_i = 1'b0;
  logic                 start_i = 1'b0;
  logic [N_CH-1:0]      ch_mask_i = '0;
  logic [CNT_W-1:0]     n_rep_i = '0;
  addr_vec_t            src_base_i = '0;
  addr_vec_t            dst_base_i = '0;
  logic [AW-1:0]        src_rep_stride_i = '0;
  logic [AW-1:0]        dst_rep_stride_i = '0;
  logic [TO_W-1:0]      timeout_i = '0;
  logic [N_CH-1:0]      sink_done_i = '0;
  logic [N_CH-1:0]      fifo_empty_i = '1;
  logic [N_CH-1:0]      src_valid_o, dst_valid_o;
  addr_vec_t            src_addr_o, dst_addr_o;
  logic                 busy_o, done_o, timeout_o;
  logic [CNT_W-1:0]     rep_cnt_o;

  datamover_rep_sched #(.N_CH(N_CH), .AW(AW), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .ch_mask_i(ch_mask_i), .n_rep_i(n_rep_i),
    .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .src_rep_stride_i(src_rep_stride_i), .dst_rep_stride_i(dst_rep_stride_i),
    .timeout_i(timeout_i), .sink_done_i(sink_done_i), .fifo_empty_i(fifo_empty_i),
    .src_valid_o(src_valid_o), .dst_valid_o(dst_valid_o),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .rep_cnt_o(rep_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- job description ----------------
  logic [N_CH-1:0]  cfg_mask;
  logic [CNT_W-1:0] cfg_nrep;
  addr_vec_t        cfg_src_base, cfg_dst_base;
  logic [AW-1:0]    cfg_src_stride, cfg_dst_stride;
  logic [TO_W-1:0]  cfg_timeout;
  int done_off  [MAX_REP][N_CH];
  int empty_off [MAX_REP][N_CH];
  int clr_rep, clr_off, rs_rep, rs_off;

  // ---------------- model results / observations ----------------
  int w_start [MAX_REP];
  int c_cyc   [MAX_REP];
  int n_act, done_cyc;
  bit exp_abort;
  int obs_done_cyc, obs_valid_cnt;
  bit obs_to;
  logic [AW-1:0] exp_q[$];

  task automatic set_defaults();
    cfg_mask = '1; cfg_nrep = CNT_W'(1);
    cfg_src_base = '0; cfg_dst_base = '0;
    cfg_src_stride = '0; cfg_dst_stride = '0; cfg_timeout = '0;
    for (int r = 0; r < MAX_REP; r++)
      for (int i = 0; i < N_CH; i++) begin
        done_off[r][i] = 0; empty_off[r][i] = 0;
      end
    clr_rep = -1; clr_off = 0; rs_rep = -1; rs_off = 0;
  endtask

  function automatic addr_vec_t rep_addr(input addr_vec_t base, input logic [AW-1:0] stride,
                                         input int r);
    addr_vec_t a;
    for (int i = 0; i < N_CH; i++) a[i] = base[i] + stride * AW'(r);
    return a;
  endfunction

  // Timeline: start at cycle 0, first WORKING cycle at 3. A repetition whose
  // WORKING starts at w completes at w + (latest channel offset); the next one
  // starts WORKING three cycles later, the final one reports done one later.
  // With timeout T, a repetition not complete within T WORKING cycles aborts
  // at w + T.
  task automatic plan_job();
    int reps, w, c_off;
    bit stop;
    n_act = 0; exp_abort = 0; done_cyc = 1; stop = 0;
    if (cfg_mask != '0) begin
      reps = (cfg_nrep == '0) ? 1 : int'(cfg_nrep);
      w = 3;
      for (int r = 0; r < reps && !stop; r++) begin
        w_start[r] = w; n_act = r + 1; c_off = 0;
        for (int i = 0; i < N_CH; i++)
          if (cfg_mask[i]) begin
            if (done_off[r][i]  > c_off) c_off = done_off[r][i];
            if (empty_off[r][i] > c_off) c_off = empty_off[r][i];
          end
        if (cfg_timeout != '0 && c_off >= int'(cfg_timeout)) begin
          exp_abort = 1; done_cyc = w + int'(cfg_timeout); stop = 1;
        end else begin
          c_cyc[r] = w + c_off;
          if (r == reps - 1) done_cyc = c_cyc[r] + 1;
          else w = c_cyc[r] + 3;
        end
      end
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_rep_cnt(input int n);
    int cnt = 0;
    for (int r = 0; r < n_act; r++)
      if (!(exp_abort && r == n_act - 1) && c_cyc[r] < n) cnt++;
    return CNT_W'(cnt);
  endfunction

  // Drives one job cycle by cycle, comparing every output against the model.
  task automatic run_job();
    int last, clear_at, restart_at, vr, r_act, o;
    logic [N_CH-1:0] ev;
    logic exp_b;
    addr_vec_t ea_s, ea_d, rv;
    plan_job();
    clear_at   = (clr_rep >= 0 && clr_rep < n_act) ? w_start[clr_rep] + clr_off : -1;
    restart_at = (rs_rep  >= 0 && rs_rep  < n_act) ? w_start[rs_rep]  + rs_off  : -1;
    last = (clear_at >= 0) ? clear_at + 1 : done_cyc + 1;
    obs_done_cyc = -1; obs_to = 0; obs_valid_cnt = 0;
    exp_q.delete();
    for (int r = 0; r < n_act; r++) exp_q.push_back(cfg_src_base[0] + cfg_src_stride * AW'(r));

    for (int n = 0; n <= last; n++) begin
      @(posedge clk_i); #1;
      if (clear_at >= 0 && n == clear_at + 1) begin
        checks++;
        if ({src_valid_o, dst_valid_o, busy_o, done_o, timeout_o} !== '0) begin
          errors++;
          $display("FAIL clear_ctrl cyc=%0d got sv=%b dv=%b busy=%b done=%b to=%b exp all 0",
                   n, src_valid_o, dst_valid_o, busy_o, done_o, timeout_o);
        end
        checks++;
        if (src_addr_o !== '0 || dst_addr_o !== '0 || rep_cnt_o !== '0) begin
          errors++;
          $display("FAIL clear_data cyc=%0d got src=%h dst=%h rep=%0d exp 0",
                   n, src_addr_o, dst_addr_o, rep_cnt_o);
        end
      end else begin
        ev = '0; vr = -1;
        for (int r = 0; r < n_act; r++)
          if (n == w_start[r] - 1) begin ev = cfg_mask; vr = r; end
        checks++;
        if (src_valid_o !== ev) begin
          errors++; $display("FAIL src_valid cyc=%0d got=%b exp=%b", n, src_valid_o, ev);
        end
        checks++;
        if (dst_valid_o !== ev) begin
          errors++; $display("FAIL dst_valid cyc=%0d got=%b exp=%b", n, dst_valid_o, ev);
        end
        exp_b = (n >= 1 && n <= done_cyc);
        checks++;
        if (busy_o !== exp_b) begin
          errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", n, busy_o, exp_b);
        end
        exp_b = (n == done_cyc);
        checks++;
        if (done_o !== exp_b) begin
          errors++; $display("FAIL done cyc=%0d got=%b exp=%b", n, done_o, exp_b);
        end
        exp_b = (n == done_cyc) && exp_abort;
        checks++;
        if (timeout_o !== exp_b) begin
          errors++; $display("FAIL timeout cyc=%0d got=%b exp=%b", n, timeout_o, exp_b);
        end
        if (|src_valid_o) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL extra_launch cyc=%0d got addr=%h exp no launch", n, src_addr_o[0]);
          end else begin
            ea_s[0] = exp_q.pop_front();
            if (src_addr_o[0] !== ea_s[0]) begin
              errors++; $display("FAIL launch_addr cyc=%0d got=%h exp=%h", n, src_addr_o[0], ea_s[0]);
            end
          end
        end
        if (vr >= 0 || (n == done_cyc && n_act > 0)) begin
          if (vr < 0) vr = n_act - 1;
          ea_s = rep_addr(cfg_src_base, cfg_src_stride, vr);
          ea_d = rep_addr(cfg_dst_base, cfg_dst_stride, vr);
          checks++;
          if (src_addr_o !== ea_s || dst_addr_o !== ea_d) begin
            errors++;
            $display("FAIL addrs cyc=%0d got src=%h dst=%h exp src=%h dst=%h",
                     n, src_addr_o, dst_addr_o, ea_s, ea_d);
          end
        end
        if (n >= 2 && n_act > 0) begin
          checks++;
          if (rep_cnt_o !== exp_rep_cnt(n)) begin
            errors++; $display("FAIL rep_cnt cyc=%0d got=%0d exp=%0d", n, rep_cnt_o, exp_rep_cnt(n));
          end
        end
      end
      if (done_o && obs_done_cyc < 0) obs_done_cyc = n;
      if (timeout_o) obs_to = 1;
      if (|src_valid_o) obs_valid_cnt++;

      // drive inputs for cycle n
      if (n == last) begin
        start_i = 1'b0; clear_i = 1'b0; sink_done_i = '0; fifo_empty_i = '1;
      end else begin
        start_i = (n == 0) || (n == restart_at);
        clear_i = (n == clear_at);
        ch_mask_i = (n == 0) ? cfg_mask : N_CH'($urandom);
        n_rep_i   = (n == 0) ? cfg_nrep : CNT_W'($urandom);
        for (int i = 0; i < N_CH; i++) rv[i] = $urandom;
        src_base_i = (n <= 1) ? cfg_src_base : rv;
        for (int i = 0; i < N_CH; i++) rv[i] = $urandom;
        dst_base_i = (n <= 1) ? cfg_dst_base : rv;
        src_rep_stride_i = cfg_src_stride; dst_rep_stride_i = cfg_dst_stride;
        timeout_i = cfg_timeout;
        r_act = -1;
        for (int r = 0; r < n_act; r++) if (w_start[r] <= n) r_act = r;
        if (r_act < 0) begin
          sink_done_i = N_CH'($urandom); fifo_empty_i = N_CH'($urandom);
        end else begin
          o = n - w_start[r_act];
          for (int i = 0; i < N_CH; i++) begin
            sink_done_i[i]  = (o >= done_off[r_act][i]);
            fifo_empty_i[i] = (o >= empty_off[r_act][i]);
          end
        end
      end
    end
    if (clear_at < 0) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++; $display("FAIL missing_launch got %0d launches short", exp_q.size());
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({busy_o, done_o, timeout_o, src_valid_o, dst_valid_o} !== '0) begin
      errors++; $display("FAIL reset_ctrl got busy=%b done=%b to=%b sv=%b dv=%b exp 0",
                         busy_o, done_o, timeout_o, src_valid_o, dst_valid_o);
    end
    checks++;
    if (src_addr_o !== '0 || dst_addr_o !== '0) begin
      errors++; $display("FAIL reset_addr got src=%h dst=%h exp 0", src_addr_o, dst_addr_o);
    end
    checks++;
    if (rep_cnt_o !== '0) begin
      errors++; $display("FAIL reset_rep_cnt got=%0d exp=0", rep_cnt_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    set_defaults();
    cfg_mask = 2'b11; done_off[0][0] = 2; done_off[0][1] = 6;
    run_job();
    checks++;
    if (obs_done_cyc !== 10 || obs_to !== 1'b0) begin
      errors++; $display("FAIL basic_done got cyc=%0d to=%b exp cyc=10 to=0", obs_done_cyc, obs_to);
    end
    checks++;
    if (rep_cnt_o !== CNT_W'(1)) begin
      errors++; $display("FAIL basic_rep_cnt got=%0d exp=1", rep_cnt_o);
    end
  endtask

  task automatic test_reps();
    set_defaults();
    cfg_nrep = CNT_W'(3); cfg_src_base[0] = 32'h1000; cfg_src_base[1] = 32'h8000;
    cfg_src_stride = 32'h100; cfg_dst_stride = 32'h40;
    for (int r = 0; r < 3; r++) begin
      done_off[r][0] = $urandom_range(0, 5); done_off[r][1] = $urandom_range(0, 5);
    end
    run_job();
    checks++;
    if (obs_valid_cnt !== 3 || rep_cnt_o !== CNT_W'(3)) begin
      errors++; $display("FAIL reps_count got launches=%0d rep=%0d exp 3/3", obs_valid_cnt, rep_cnt_o);
    end
    checks++;
    if (src_addr_o[0] !== 32'h1200) begin
      errors++; $display("FAIL reps_last_addr got=%h exp=00001200", src_addr_o[0]);
    end
  endtask

  task automatic test_fifo_wait();
    set_defaults();
    done_off[0][0] = 1; empty_off[0][0] = 5;
    run_job();
    checks++;
    if (obs_done_cyc !== 9) begin
      errors++; $display("FAIL fifo_wait got done cyc=%0d exp=9", obs_done_cyc);
    end
  endtask

  task automatic test_timeout();
    set_defaults();
    cfg_timeout = TO_W'(10); done_off[0][0] = 2; done_off[0][1] = NEVER;
    run_job();
    checks++;
    if (obs_done_cyc !== 13 || obs_to !== 1'b1) begin
      errors++; $display("FAIL timeout_abort got cyc=%0d to=%b exp cyc=13 to=1", obs_done_cyc, obs_to);
    end
    // completion in the final allowed cycle beats the timeout
    set_defaults();
    cfg_timeout = TO_W'(6); done_off[0][0] = 5;
    run_job();
    checks++;
    if (obs_done_cyc !== 9 || obs_to !== 1'b0) begin
      errors++; $display("FAIL timeout_tie got cyc=%0d to=%b exp cyc=9 to=0", obs_done_cyc, obs_to);
    end
    // abort in the second repetition keeps the first one's count and addresses
    set_defaults();
    cfg_nrep = CNT_W'(3); cfg_timeout = TO_W'(4); cfg_src_stride = 32'h20;
    done_off[1][1] = NEVER;
    run_job();
    checks++;
    if (rep_cnt_o !== CNT_W'(1) || src_addr_o[1] !== 32'h20) begin
      errors++; $display("FAIL timeout_hold got rep=%0d addr=%h exp rep=1 addr=00000020",
                         rep_cnt_o, src_addr_o[1]);
    end
  endtask

  task automatic test_zero_mask();
    set_defaults();
    cfg_mask = '0; cfg_nrep = CNT_W'(4);
    run_job();
    checks++;
    if (obs_done_cyc !== 1 || obs_valid_cnt !== 0) begin
      errors++; $display("FAIL zero_mask got done cyc=%0d launches=%0d exp 1/0", obs_done_cyc, obs_valid_cnt);
    end
    set_defaults();
    cfg_nrep = '0; done_off[0][1] = 3;
    run_job();
    checks++;
    if (obs_valid_cnt !== 1 || rep_cnt_o !== CNT_W'(1)) begin
      errors++; $display("FAIL zero_rep got launches=%0d rep=%0d exp 1/1", obs_valid_cnt, rep_cnt_o);
    end
  endtask

  task automatic test_clear_restart();
    set_defaults();
    cfg_nrep = CNT_W'(3); cfg_src_base[0] = 32'h4000; cfg_src_stride = 32'h10;
    done_off[1][0] = 6; clr_rep = 1; clr_off = 2;
    run_job();
    // start pulsed mid-WORKING must not disturb a normal job
    set_defaults();
    cfg_nrep = CNT_W'(2); done_off[0][0] = 4; rs_rep = 0; rs_off = 1;
    run_job();
    checks++;
    if (obs_valid_cnt !== 2 || rep_cnt_o !== CNT_W'(2)) begin
      errors++; $display("FAIL restart_ignored got launches=%0d rep=%0d exp 2/2", obs_valid_cnt, rep_cnt_o);
    end
  endtask

  task automatic test_wrap();
    set_defaults();
    cfg_nrep = CNT_W'(2); cfg_dst_base[0] = 32'hFFFF_FF80; cfg_dst_stride = 32'h100;
    run_job();
    checks++;
    if (dst_addr_o[0] !== 32'h0000_0080) begin
      errors++; $display("FAIL wrap got=%h exp=00000080", dst_addr_o[0]);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      set_defaults();
      cfg_mask = N_CH'($urandom);
      cfg_nrep = CNT_W'($urandom_range(0, 4));
      for (int i = 0; i < N_CH; i++) begin
        cfg_src_base[i] = $urandom; cfg_dst_base[i] = $urandom;
      end
      cfg_src_stride = $urandom; cfg_dst_stride = $urandom;
      cfg_timeout = ($urandom_range(0, 1) == 1) ? TO_W'($urandom_range(2, 12)) : '0;
      for (int r = 0; r < MAX_REP; r++)
        for (int i = 0; i < N_CH; i++) begin
          done_off[r][i]  = $urandom_range(0, 10);
          empty_off[r][i] = $urandom_range(0, 10);
          if (cfg_timeout != '0 && $urandom_range(0, 7) == 0) done_off[r][i] = NEVER;
        end
      run_job();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reps();
    test_fifo_wait();
    test_timeout();
    test_zero_mask();
    test_clear_restart();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
